// File: rtl/binary_box_detect.sv
// Bounding-box detector for a 1-bit pixel stream: run-length noise filter inside a fixed ROI,
// box/pixel-count/found latched and pulsed on box_valid once at every frame end.
module binary_box_detect #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int ROI_LEFT  = 47,
  parameter int ROI_RIGHT = 567,
  parameter int ROI_UP    = 44,
  parameter int ROI_DOWN  = 380,
  parameter int RUN_MIN   = 3,
  parameter int MIN_PIX   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_Bit,
  output logic [9:0]  box_left,
  output logic [9:0]  box_right,
  output logic [9:0]  box_up,
  output logic [9:0]  box_down,
  output logic [18:0] box_pix_cnt,
  output logic        box_found,
  output logic        box_valid
);

  typedef enum logic [1:0] {S_WAIT, S_BLANK, S_FRAME, S_END} state_t;

  localparam logic [9:0]  X_LAST    = 10'(IMG_HDISP - 1);
  localparam logic [9:0]  Y_MAX     = 10'h3ff;
  localparam logic [9:0]  ROI_X0    = 10'(ROI_LEFT);
  localparam logic [9:0]  ROI_XSPAN = 10'(ROI_RIGHT - ROI_LEFT);
  localparam logic [9:0]  ROI_Y0    = 10'(ROI_UP);
  localparam logic [9:0]  ROI_YSPAN = 10'(ROI_DOWN - ROI_UP);
  localparam logic [3:0]  RUN_TH    = 4'(RUN_MIN);
  localparam logic [3:0]  RUN_PRE   = 4'(RUN_MIN - 1);
  localparam logic [9:0]  RUN_BACK  = 10'(RUN_MIN - 1);
  localparam logic [18:0] RUN_ADD   = 19'(RUN_MIN);
  localparam logic [18:0] MIN_CNT   = 19'(MIN_PIX);
  localparam int          unused_vdisp = IMG_VDISP;

  state_t      state_q, state_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [3:0]  run_q, run_d;
  logic [9:0]  min_x_q, min_x_d;
  logic [9:0]  max_x_q, max_x_d;
  logic [9:0]  min_y_q, min_y_d;
  logic [9:0]  max_y_q, max_y_d;
  logic [18:0] pix_q, pix_d;
  logic [9:0]  left_q, left_d;
  logic [9:0]  right_q, right_d;
  logic [9:0]  up_q, up_d;
  logic [9:0]  down_q, down_d;
  logic [18:0] cnt_q, cnt_d;
  logic        found_q, found_d;
  logic        valid_q, valid_d;

  logic        rise, fall;
  logic        in_roi;
  logic        pix_on;
  logic        run_first;
  logic        counted;
  logic [3:0]  run_inc;
  logic [9:0]  cand_left;
  logic [18:0] pix_add;
  logic        acc_clr;
  logic        acc_en;
  logic [19:0] pix_sum;
  logic [9:0]  min_x_b, max_x_b, min_y_b, max_y_b;
  logic [18:0] pix_b;
  logic        unused_href_probe;

  assign vsync_d = per_frame_vsync;
  assign href_d  = per_frame_href;
  assign rise    = per_frame_vsync & ~vsync_q;
  assign fall    = ~per_frame_vsync & vsync_q;

  // href is kept registered as a debug probe only; clken alone qualifies pixels
  assign unused_href_probe = href_q;

  // Offset-and-span compare keeps the ROI test free of constant comparisons when an edge is 0
  assign in_roi = ((x_q - ROI_X0) <= ROI_XSPAN) && ((y_q - ROI_Y0) <= ROI_YSPAN);

  assign pix_on    = per_frame_clken & ~per_frame_vsync & per_img_Bit & in_roi;
  assign run_inc   = (run_q >= RUN_TH) ? RUN_TH : run_q + 4'd1;
  assign run_first = pix_on && (run_q == RUN_PRE);
  assign counted   = pix_on && (run_inc == RUN_TH);
  assign cand_left = run_first ? (x_q - RUN_BACK) : x_q;
  assign pix_add   = run_first ? RUN_ADD : 19'd1;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    run_d = run_q;
    if (per_frame_vsync) begin
      x_d   = 10'd0;
      y_d   = 10'd0;
      run_d = 4'd0;
    end else if (per_frame_clken) begin
      if (x_q == X_LAST) begin
        x_d = 10'd0;
        if (y_q != Y_MAX) begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
      if (per_img_Bit && in_roi) begin
        run_d = run_inc;
      end else begin
        run_d = 4'd0;
      end
      // a run never continues across a line boundary
      if (x_q == X_LAST) begin
        run_d = 4'd0;
      end
    end
  end

  // The fall cycle both clears the accumulators and may carry the frame's first pixel
  assign acc_clr = (state_q == S_BLANK) && fall;
  assign acc_en  = (state_q == S_FRAME) || acc_clr;
  assign min_x_b = acc_clr ? 10'h3ff : min_x_q;
  assign max_x_b = acc_clr ? 10'd0   : max_x_q;
  assign min_y_b = acc_clr ? 10'h3ff : min_y_q;
  assign max_y_b = acc_clr ? 10'd0   : max_y_q;
  assign pix_b   = acc_clr ? 19'd0   : pix_q;
  assign pix_sum = {1'b0, pix_b} + {1'b0, pix_add};

  always_comb begin
    min_x_d = min_x_b;
    max_x_d = max_x_b;
    min_y_d = min_y_b;
    max_y_d = max_y_b;
    pix_d   = pix_b;
    if (acc_en && counted) begin
      pix_d = pix_sum[19] ? {19{1'b1}} : pix_sum[18:0];
      if (cand_left < min_x_b) begin
        min_x_d = cand_left;
      end
      if (x_q > max_x_b) begin
        max_x_d = x_q;
      end
      if (y_q < min_y_b) begin
        min_y_d = y_q;
      end
      if (y_q > max_y_b) begin
        max_y_d = y_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    left_d  = left_q;
    right_d = right_q;
    up_d    = up_q;
    down_d  = down_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    case (state_q)
      S_WAIT: begin
        if (per_frame_vsync) begin
          state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        if (fall) begin
          state_d = S_FRAME;
        end
      end
      S_FRAME: begin
        if (rise) begin
          state_d = S_END;
        end
      end
      S_END: begin
        valid_d = 1'b1;
        cnt_d   = pix_q;
        if (pix_q >= MIN_CNT) begin
          left_d  = min_x_q;
          right_d = max_x_q;
          up_d    = min_y_q;
          down_d  = max_y_q;
          found_d = 1'b1;
        end else begin
          left_d  = 10'd0;
          right_d = 10'd0;
          up_d    = 10'd0;
          down_d  = 10'd0;
          found_d = 1'b0;
        end
        state_d = S_BLANK;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      run_q   <= 4'd0;
      min_x_q <= 10'h3ff;
      max_x_q <= 10'd0;
      min_y_q <= 10'h3ff;
      max_y_q <= 10'd0;
      pix_q   <= 19'd0;
      left_q  <= 10'd0;
      right_q <= 10'd0;
      up_q    <= 10'd0;
      down_q  <= 10'd0;
      cnt_q   <= 19'd0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      x_q     <= x_d;
      y_q     <= y_d;
      run_q   <= run_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      pix_q   <= pix_d;
      left_q  <= left_d;
      right_q <= right_d;
      up_q    <= up_d;
      down_q  <= down_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      valid_q <= valid_d;
    end
  end

  assign box_left    = left_q;
  assign box_right   = right_q;
  assign box_up      = up_q;
  assign box_down    = down_q;
  assign box_pix_cnt = cnt_q;
  assign box_found   = found_q;
  assign box_valid   = valid_q;

endmodule
